icache_responder: RTL

Direct-mapped, read-only instruction cache that answers the CPU's instruction fetch. It takes the PC from the CPU, returns the 32-bit instruction, and stalls the CPU with `busywait` on a miss. It refills whole blocks from the instruction memory over a read/busywait handshake. It sits between the CPU fetch port and the instruction memory, in place of direct combinational fetch.

---
 rtl/icache_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and
// instruction memory. Hits return combinationally; misses stall and refill a whole block.
module icache_responder #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic [31:0]                                   PC,
    output logic [31:0]                                   INSTRUCTION,
    output logic                                          busywait,
    output logic                                          imem_read,
    output logic [ADDR_WIDTH-3-$clog2(BLOCK_WORDS):0]     imem_address,
    input  logic [32*BLOCK_WORDS-1:0]                     imem_readdata,
    input  logic                                          imem_busywait
);

    localparam int IDX      = $clog2(NUM_BLOCKS);
    localparam int OFF      = $clog2(BLOCK_WORDS);
    localparam int TAG      = ADDR_WIDTH - IDX - OFF - 2;
    localparam int BLK_ADDR = TAG + IDX;
    localparam int BLK_BITS = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_READ = 2'b01,
        ST_UPDATE   = 2'b10
    } state_t;

    state_t                state_r;
    logic [NUM_BLOCKS-1:0] valid_r;
    logic [TAG-1:0]        tag_r  [NUM_BLOCKS];
    logic [BLK_BITS-1:0]   data_r [NUM_BLOCKS];
    logic [BLK_BITS-1:0]   fill_buf_r;
    logic [BLK_ADDR-1:0]   imem_address_r;
    logic                  imem_read_r;

    logic [IDX-1:0]        pc_idx_s;
    logic [OFF-1:0]        pc_off_s;
    logic [TAG-1:0]        pc_tag_s;
    logic [IDX-1:0]        fill_idx_s;
    logic [TAG-1:0]        fill_tag_s;
    logic                  hit_s;
    logic                  busywait_s;
    logic                  unused_pc_s;

    assign pc_off_s    = PC[OFF+1:2];
    assign pc_idx_s    = PC[OFF+2+IDX-1:OFF+2];
    assign pc_tag_s    = PC[ADDR_WIDTH-1:OFF+2+IDX];
    assign unused_pc_s = ^{PC[31:ADDR_WIDTH], PC[1:0]};

    // The latched block address doubles as the refill target line
    assign fill_idx_s = imem_address_r[IDX-1:0];
    assign fill_tag_s = imem_address_r[BLK_ADDR-1:IDX];

    assign hit_s        = valid_r[pc_idx_s] && (tag_r[pc_idx_s] == pc_tag_s);
    assign INSTRUCTION  = data_r[pc_idx_s][{pc_off_s, 5'b00000} +: 32];
    assign imem_read    = imem_read_r;
    assign imem_address = imem_address_r;
    assign busywait     = busywait_s;

    // Stall request: immediate on an IDLE miss, held through the whole refill
    always_comb begin
        busywait_s = 1'b0;
        if (!RESET) begin
            busywait_s = 1'b0;
        end else if (state_r != ST_IDLE) begin
            busywait_s = 1'b1;
        end else begin
            busywait_s = !hit_s;
        end
    end

    // Refill FSM with registered memory-request outputs and line storage
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r        <= ST_IDLE;
            valid_r        <= '0;
            imem_read_r    <= 1'b0;
            imem_address_r <= '0;
            fill_buf_r     <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!hit_s) begin
                        imem_address_r <= {pc_tag_s, pc_idx_s};
                        imem_read_r    <= 1'b1;
                        state_r        <= ST_MEM_READ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEM_READ: begin
                    if (!imem_busywait) begin
                        fill_buf_r  <= imem_readdata;
                        imem_read_r <= 1'b0;
                        state_r     <= ST_UPDATE;
                    end else begin
                        state_r <= ST_MEM_READ;
                    end
                end
                ST_UPDATE: begin
                    data_r[fill_idx_s]  <= fill_buf_r;
                    tag_r[fill_idx_s]   <= fill_tag_s;
                    valid_r[fill_idx_s] <= 1'b1;
                    state_r             <= ST_IDLE;
                end
                default: begin
                    imem_read_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
